// File: rtl/vga_if.sv
// Signal bundle between the VGA timing generator and its pixel source / display sink.
// pix_req pulses for one clk with pix_x/pix_y valid; there is no ready, so the source
// must present pix_in for that coordinate before the next pixel tick.
interface vga_if #(
    parameter int CW = 4,
    parameter int XW = 10,
    parameter int YW = 10
) ();
    logic [1:0]      mode;
    logic [3*CW-1:0] color_in;
    logic [3*CW-1:0] pix_in;
    logic [XW-1:0]   pix_x;
    logic [YW-1:0]   pix_y;
    logic            pix_req;
    logic            line_start;
    logic            frame_start;
    logic            hsync;
    logic            vsync;
    logic            de;
    logic [CW-1:0]   red;
    logic [CW-1:0]   green;
    logic [CW-1:0]   blue;

    modport master (
        input  mode, color_in, pix_in,
        output pix_x, pix_y, pix_req, line_start, frame_start,
        output hsync, vsync, de, red, green, blue
    );

    modport slave (
        output mode, color_in, pix_in,
        input  pix_x, pix_y, pix_req, line_start, frame_start,
        input  hsync, vsync, de, red, green, blue
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-tick divider, x/y raster counters and a
// one-tick-delayed output register carrying sync, data enable and RGB.
module vga_timing_gen #(
    parameter int CW   = 4,
    parameter int DIV  = 4,
    parameter int HD   = 640,
    parameter int HF   = 16,
    parameter int HS   = 96,
    parameter int HB   = 48,
    parameter int VD   = 480,
    parameter int VF   = 10,
    parameter int VS   = 2,
    parameter int VB   = 33,
    parameter bit HPOL = 1'b0,
    parameter bit VPOL = 1'b0,
    parameter int XW   = 10,
    parameter int YW   = 10
) (
    input  logic clk,
    input  logic reset,
    vga_if.master bus
);
    localparam int HT  = HD + HF + HS + HB;
    localparam int VT  = VD + VF + VS + VB;
    localparam int DVW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DVW-1:0] DIV_MAX  = DVW'(DIV - 1);
    localparam logic [XW-1:0]  X_MAX    = XW'(HT - 1);
    localparam logic [XW-1:0]  X_ACT    = XW'(HD);
    localparam logic [XW-1:0]  X_SYN_LO = XW'(HD + HF);
    localparam logic [XW-1:0]  X_SYN_HI = XW'(HD + HF + HS);
    localparam logic [YW-1:0]  Y_MAX    = YW'(VT - 1);
    localparam logic [YW-1:0]  Y_ACT    = YW'(VD);
    localparam logic [YW-1:0]  Y_SYN_LO = YW'(VD + VF);
    localparam logic [YW-1:0]  Y_SYN_HI = YW'(VD + VF + VS);

    localparam logic [1:0] MODE_EXT   = 2'd0;
    localparam logic [1:0] MODE_SOLID = 2'd1;
    localparam logic [1:0] MODE_BARS  = 2'd2;

    logic [DVW-1:0]  div_q, div_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [1:0]      mode_q, mode_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            de_q, de_d;
    logic [3*CW-1:0] rgb_q, rgb_d;

    logic            tick;
    logic            tick_out;
    logic            frame_first;
    logic            active;
    logic [1:0]      mode_eff;
    logic [2:0]      bar_idx;
    logic [3*CW-1:0] pattern;

    assign tick        = (div_q == DIV_MAX);
    assign tick_out    = tick && !reset;
    assign frame_first = (x_q == '0) && (y_q == '0);
    assign active      = (x_q < X_ACT) && (y_q < Y_ACT);
    // The new frame's mode already applies to its first pixel, hence the bypass.
    assign mode_eff    = frame_first ? bus.mode : mode_q;

    // Bar k starts at the first x with x*8 >= k*HD, i.e. ceil(k*HD/8).
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x_q >= XW'((k * HD + 7) / 8)) begin
                bar_idx = 3'(k);
            end
        end
    end

    always_comb begin
        pattern = bus.pix_in;
        case (mode_eff)
            MODE_EXT:   pattern = bus.pix_in;
            MODE_SOLID: pattern = bus.color_in;
            MODE_BARS:  pattern = {{CW{bar_idx[2]}}, {CW{bar_idx[1]}}, {CW{bar_idx[0]}}};
            default:    pattern = (x_q[3] ^ y_q[3]) ? ~bus.color_in : bus.color_in;
        endcase
    end

    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        rgb_d   = rgb_q;
        if (tick) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            if (frame_first) begin
                mode_d = bus.mode;
            end
            hsync_d = ((x_q >= X_SYN_LO) && (x_q < X_SYN_HI)) ? HPOL : ~HPOL;
            vsync_d = ((y_q >= Y_SYN_LO) && (y_q < Y_SYN_HI)) ? VPOL : ~VPOL;
            de_d    = active;
            rgb_d   = active ? pattern : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= MODE_EXT;
            hsync_q <= ~HPOL;
            vsync_q <= ~VPOL;
            de_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
        end
    end

    assign bus.pix_x       = x_q;
    assign bus.pix_y       = y_q;
    assign bus.pix_req     = tick_out && active;
    assign bus.line_start  = tick_out && (x_q == '0);
    assign bus.frame_start = tick_out && frame_first;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.de          = de_q;
    assign bus.red         = rgb_q[3*CW-1:2*CW];
    assign bus.green       = rgb_q[2*CW-1:CW];
    assign bus.blue        = rgb_q[CW-1:0];
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA output block. Generates horizontal/vertical timing from a system clock via a programmable pixel-tick divider. Exposes pixel coordinates and a pixel request so an upstream framebuffer or renderer can supply pixel data. Drives RGB from either that external data or one of three built-in test patterns, with configurable sync polarity and colour depth.

Parameters:
CW, 4, bits per colour channel
DIV, 4, system clocks per pixel tick (>=1; DIV=1 means a tick every clock)
HD, 640, active pixels per line
HF, 16, horizontal front porch
HS, 96, horizontal sync width
HB, 48, horizontal back porch
VD, 480, active lines per frame
VF, 10, vertical front porch
VS, 2, vertical sync width
VB, 33, vertical back porch
HPOL, 0, hsync active level (0 = active-low)
VPOL, 0, vsync active level
XW, 10, width of x counter (must hold HD+HF+HS+HB-1)
YW, 10, width of y counter (must hold VD+VF+VS+VB-1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mode  in  2  0 external, 1 solid, 2 colour bars, 3 checkerboard
color_in  in  3*CW  {R,G,B} for solid/checker modes
pix_in  in  3*CW  {R,G,B} external pixel for the coordinate issued on the previous tick
pix_x  out  XW  current horizontal count
pix_y  out  YW  current vertical count
pix_req  out  1  high for one clk on each tick where (pix_x<HD && pix_y<VD)
line_start  out  1  one-clk pulse on the tick where pix_x wraps to 0
frame_start  out  1  one-clk pulse on the tick where pix_x and pix_y both wrap to 0
hsync  out  1  horizontal sync, polarity HPOL
vsync  out  1  vertical sync, polarity VPOL
de  out  1  data enable (active video)
red / green / blue  out  CW each  colour outputs, forced to 0 when de=0

Behaviour:
- Tick divider: counter 0..DIV-1, tick when it equals DIV-1; wraps to 0. DIV=1 gives a tick every cycle.
- Counters advance only on tick. x: 0..HT-1, where HT=HD+HF+HS+HB. y: 0..VT-1, where VT=VD+VF+VS+VB. y increments when x wraps; y wraps to 0 when both are at max.
- Region order per line: active, front porch, sync, back porch. Same order vertically.
- Sync is active for x in [HD+HF, HD+HF+HS-1]; likewise for y.
- Output stage is registered on tick. hsync, vsync, de and RGB reflect the counter value from the previous tick, so the outputs lag pix_x/pix_y by exactly one tick.
- pix_in is sampled in that same register, so the upstream source has one tick to respond to pix_req.
- Pattern generation, using the x/y from the previous tick:
  - Solid: color_in.
  - Bars: 8 vertical bars, bar index = x*8/HD (integer division), colour index 0..7 encoded as {R,G,B} = {b2,b1,b0}, with each set channel at all-ones.
  - Checker: x[3]^y[3] selects color_in when 0, bitwise ~color_in when 1.
- Mode latch: mode is captured into an internal register only on the frame_start tick. Mid-frame changes do not affect the current frame.
- pix_req, line_start and frame_start are single-clk pulses aligned with the tick; they are never asserted on non-tick cycles.
- Reset:
  - Divider, x and y counters go to 0.
  - Mode latch goes to 0 (external).
  - hsync=~HPOL, vsync=~VPOL (inactive), de=0, RGB=0.
  - pix_req, line_start and frame_start are 0 in the reset cycle.
  - The first tick after reset release comes DIV clks later and asserts frame_start and line_start (x=y=0).
  - Reset mid-frame aborts immediately with no partial-line recovery.
- Counter-width checks (HT<=2^XW, VT<=2^YW) are enforced by the designer, not in RTL.

Test Plan:
- Reset with DIV=4 and defaults, then release -> first tick at clk 4 with frame_start=line_start=1; the line period is 800 ticks = 3200 clks; the frame period is 525 lines = 1680000 clks.
- Small config HD=8, HF=2, HS=3, HB=1, VD=4, VF=1, VS=2, VB=1, DIV=1, HPOL=VPOL=0 -> hsync low exactly during output ticks for x=10..12; vsync low during y=5..6; de high for 8 ticks per line on 4 lines.
- Small config, mode=0, pix_in = {x[3:0], y[3:0], 4'hA} driven combinationally -> RGB on the tick after pix_x=5, pix_y=2 equals {5, 2, A}; RGB is 0 whenever de=0.
- Default config, mode=2 -> x=0..79 outputs 000, x=80..159 outputs 00F, ..., x=560..639 outputs FFF.
- mode switched from 1 to 3 mid-frame with color_in=12'h123 -> the frame stays solid 123 until the next frame_start; the following frame shows checkerboard 123 / EDC in 8x8 tiles.
- Reset asserted at x=300, y=200 for one clk -> outputs go to inactive/zero that cycle, counters restart at 0, and frame_start recurs DIV clks after release.
